// File: rtl/demux32bit1x2_reg_pkg.sv
// Shared widths and lane state type for the registered 1-to-2 demultiplexer.
package demux32bit1x2_reg_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } lane_state_t;

endpackage

// File: rtl/demux_lane_reg.sv
// One-entry lane buffer: loads a word, holds it until drained, counts loads.
//
// state | meaning
// EMPTY | no word held, valid low
// FULL  | word held on q, valid high until drained
module demux_lane_reg
  import demux32bit1x2_reg_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              drain,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q,
  output logic              valid,
  output logic              can_load,
  output logic [CNT_W-1:0]  count
);

  lane_state_t state;

  assign valid    = (state == FULL);
  // A full lane can take a new word in the same cycle it is drained.
  assign can_load = (state == EMPTY) || drain;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      q     <= '0;
      count <= '0;
    end else if (load) begin
      state <= FULL;
      q     <= d;
      count <= count + CNT_W'(1);
    end else if (state == FULL && drain) begin
      state <= EMPTY;
    end
  end

endmodule

// File: rtl/demux32bit1x2_reg.sv
// Registered 1-to-2 demultiplexer with per-lane valid/ready handshake and counters.
module demux32bit1x2_reg
  import demux32bit1x2_reg_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in,
  input  logic              sel,
  input  logic              invalid,
  output logic              inready,
  output logic [DATA_W-1:0] y0,
  output logic [DATA_W-1:0] y1,
  output logic              y0valid,
  output logic              y1valid,
  input  logic              y0ready,
  input  logic              y1ready,
  output logic [CNT_W-1:0]  count0,
  output logic [CNT_W-1:0]  count1
);

  logic can_load0, can_load1;
  logic load0, load1;

  // Only the selected lane gates acceptance, so a stalled lane never blocks the other.
  assign inready = !reset && (sel ? can_load1 : can_load0);
  assign load0   = invalid && inready && !sel;
  assign load1   = invalid && inready &&  sel;

  demux_lane_reg u_lane0 (
    .clk      (clk),
    .reset    (reset),
    .load     (load0),
    .drain    (y0ready),
    .d        (in),
    .q        (y0),
    .valid    (y0valid),
    .can_load (can_load0),
    .count    (count0)
  );

  demux_lane_reg u_lane1 (
    .clk      (clk),
    .reset    (reset),
    .load     (load1),
    .drain    (y1ready),
    .d        (in),
    .q        (y1),
    .valid    (y1valid),
    .can_load (can_load1),
    .count    (count1)
  );

endmodule

// File: tb/tb_demux32bit1x2_reg.sv
// Self-checking bench: lane scoreboards fed on acceptance, drained on consumption.
module tb_demux32bit1x2_reg;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] in = '0;
  logic        sel = 1'b0;
  logic        invalid = 1'b0;
  logic        inready;
  logic [31:0] y0, y1;
  logic        y0valid, y1valid;
  logic        y0ready = 1'b0;
  logic        y1ready = 1'b0;
  logic [15:0] count0, count1;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] sb0[$];
  logic [31:0] sb1[$];
  logic        m_f0 = 1'b0, m_f1 = 1'b0;
  logic [31:0] m_last0 = '0, m_last1 = '0;
  logic [15:0] m_cnt0 = '0, m_cnt1 = '0;
  logic        m_known = 1'b0;
  logic        m_rdy;

  always #5 clk = ~clk;

  demux32bit1x2_reg dut (
    .clk     (clk),
    .reset   (reset),
    .in      (in),
    .sel     (sel),
    .invalid (invalid),
    .inready (inready),
    .y0      (y0),
    .y1      (y1),
    .y0valid (y0valid),
    .y1valid (y1valid),
    .y0ready (y0ready),
    .y1ready (y1ready),
    .count0  (count0),
    .count1  (count1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    m_rdy = !reset && (sel ? (!m_f1 || y1ready) : (!m_f0 || y0ready));
    chk("inready", {31'b0, inready}, {31'b0, m_rdy});
    if (m_known) begin
      chk("y0valid", {31'b0, y0valid}, {31'b0, m_f0});
      chk("y1valid", {31'b0, y1valid}, {31'b0, m_f1});
      chk("y0", y0, (sb0.size() > 0) ? sb0[0] : m_last0);
      chk("y1", y1, (sb1.size() > 0) ? sb1[0] : m_last1);
      chk("count0", {16'b0, count0}, {16'b0, m_cnt0});
      chk("count1", {16'b0, count1}, {16'b0, m_cnt1});
    end
  endtask

  task automatic model_edge();
    logic acc;
    acc = invalid && m_rdy;
    if (reset) begin
      sb0.delete(); sb1.delete();
      m_f0 = 1'b0; m_f1 = 1'b0;
      m_last0 = '0; m_last1 = '0;
      m_cnt0 = '0; m_cnt1 = '0;
      m_known = 1'b1;
    end else begin
      if (m_f0 && y0ready) begin void'(sb0.pop_front()); m_f0 = 1'b0; end
      if (m_f1 && y1ready) begin void'(sb1.pop_front()); m_f1 = 1'b0; end
      if (acc && !sel) begin sb0.push_back(in); m_f0 = 1'b1; m_last0 = in; m_cnt0++; end
      if (acc &&  sel) begin sb1.push_back(in); m_f1 = 1'b1; m_last1 = in; m_cnt1++; end
    end
  endtask

  // One clock: drive inputs away from the edge, check, then advance the model at the edge.
  task automatic cyc(input logic r, input logic v, input logic s, input logic [31:0] d,
                     input logic r0, input logic r1);
    reset = r; invalid = v; sel = s; in = d; y0ready = r0; y1ready = r1;
    #1;
    check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 32'hDEAD, 1, 1);

    // single word to lane 0, drained immediately
    cyc(0, 1, 0, 32'h3E8, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);

    // backpressure on lane 0, second word enters in the draining cycle
    cyc(0, 1, 0, 32'h11, 0, 0);
    cyc(0, 1, 0, 32'h22, 0, 0);
    cyc(0, 1, 0, 32'h22, 0, 0);
    cyc(0, 1, 0, 32'h22, 1, 0);
    cyc(0, 0, 0, 0, 0, 0);

    // stalled lane 0 does not block lane 1
    cyc(0, 1, 1, 32'hABCD, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);

    // lane 0 empties, then lane 1 drains while lane 0 fills
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 1, 0, 32'h5555, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 1);

    for (int i = 0; i < 300; i++)
      cyc(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // counter wrap on lane 1 from a fresh reset
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 65536; i++)
      cyc(0, 1, 1, i, 0, 1);
    cyc(0, 0, 0, 0, 1, 1);
    chk("wrap_count1", {16'b0, count1}, 32'h0);
    chk("wrap_count0", {16'b0, count0}, 32'h0);

    // reset while both lanes full and a word is offered
    cyc(0, 1, 0, 32'hA0A0, 0, 0);
    cyc(0, 1, 1, 32'hB1B1, 0, 0);
    cyc(1, 1, 0, 32'hC2C2, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("rst_y0valid", {31'b0, y0valid}, 32'h0);
    chk("rst_y1valid", {31'b0, y1valid}, 32'h0);
    chk("rst_count0", {16'b0, count0}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/demux32bit1x2_reg.md
DEMUX32BIT1X2_REG -- requirements
Module: demux32bit1x2_reg

Interface
REQ-001: Clk  input  1  sole clock; all state updates on rising edge.
REQ-002: Reset  input  1  synchronous, active-high reset.
REQ-003: In  input  32  data word to route.
REQ-004: Sel  input  1  destination lane (0 -> lane 0, 1 -> lane 1).
REQ-005: InValid  input  1  In/Sel hold a valid word.
REQ-006: InReady  output  1  block accepts the word this cycle.
REQ-007: Y0 / Y1  output  32 each  lane 0 / lane 1 data.
REQ-008: Y0Valid / Y1Valid  output  1 each  lane holds a valid word.
REQ-009: Y0Ready / Y1Ready  input  1 each  downstream consumer takes the lane word.
REQ-010: Count0 / Count1  output  16 each  words accepted into lane 0 / lane 1.

Function
REQ-011: Each lane SHALL be a one-entry register with states EMPTY (YnValid=0) and FULL (YnValid=1).
REQ-012: Acceptance SHALL occur in a cycle where InValid=1 and InReady=1; all other cycles SHALL leave lane data unchanged.
REQ-013: InReady SHALL be combinational: 1 iff Reset=0 and the lane selected by Sel is EMPTY, or is FULL with its YnReady=1 in the same cycle.
REQ-014: Latency SHALL be one cycle: a word accepted at edge k SHALL appear on Yn with YnValid=1 after edge k.
REQ-015: Lane transitions: EMPTY + accept -> FULL; FULL + YnReady + no accept -> EMPTY; FULL + YnReady + accept -> FULL holding the new word; FULL + !YnReady -> FULL, data held.
REQ-016: A stalled lane SHALL NOT block the other lane; a word for the non-stalled lane SHALL be accepted.
REQ-017: The non-selected lane SHALL be unaffected by acceptance; its drain SHALL proceed independently in the same cycle.
REQ-018: Yn SHALL change only on acceptance into lane n; YnReady while EMPTY SHALL have no effect.
REQ-019: CountN SHALL increment by 1 on each acceptance into lane n and wrap 0xFFFF -> 0x0000.
REQ-020: Upstream SHALL hold In/Sel stable while InValid=1 and InReady=0; the block SHALL NOT check this.

Reset
REQ-021: On a rising edge with Reset=1: Y0Valid=Y1Valid=0, Y0=Y1=32'h0, Count0=Count1=0.
REQ-022: Reset SHALL override any acceptance or drain in the same cycle; a word presented in that cycle SHALL be dropped and not counted.
REQ-023: Reset asserted mid-operation SHALL discard any FULL lane contents.
REQ-024: InReady SHALL be 0 while Reset=1.

Structure
REQ-025: A shared package SHALL hold the data width constant (32), counter width constant (16), and the lane state type (EMPTY, FULL).
REQ-026: One sub-module, demux_lane_reg (one-entry lane buffer with load, drain, data, valid, counter), SHALL be instantiated twice.
REQ-027: No latches; all lane state in Clk-edge registers.

Verification
REQ-028: Reset, then In=32'h000003E8, Sel=0, InValid=1 one cycle, Y0Ready=1 -> Y0=32'h3E8, Y0Valid=1 next cycle for one cycle, Count0=1, Y1Valid stays 0.
REQ-029: Y0Ready=0, two words to lane 0 (32'h11, 32'h22) -> first accepted, InReady=0 on second until Y0Ready=1; then 32'h22 loads in the draining cycle, Y0Valid stays 1, Count0=2.
REQ-030: Lane 0 FULL and stalled, In=32'hABCD, Sel=1 -> accepted immediately, Y1=32'hABCD next cycle, Y0 unchanged.
REQ-031: Simultaneous drain of lane 1 and acceptance into lane 0 -> Y1Valid falls, Y0Valid rises in the same cycle.
REQ-032: 65536 accepts into lane 1 with Y1Ready=1 -> Count1 wraps to 0x0000, Count0 unchanged.
REQ-033: Reset asserted while both lanes FULL and InValid=1 -> next cycle both YnValid=0, both counts 0, InReady=0 during reset.
